// File: rtl/multi_point_frequency_classifier.sv
// Multi-window line-scan frequency classifier. Each window's per-line maximum is thresholded into a sample.
// Periods between sample rising edges are sorted into F0/F1/unknown counters, which are dumped over valid/ready.
module multi_point_frequency_classifier #(
  parameter int CHANNELS             = 3,
  parameter int PIXEL_INDEX_WIDTH    = 12,
  parameter int PERIOD_WIDTH         = 24,
  parameter int COUNT_WIDTH          = 32,
  parameter int CFG_ADDR_WIDTH       = 6,
  parameter int DEFAULT_THRESHOLD    = 96,
  parameter int DEFAULT_TOLERANCE    = 300,
  parameter int DEFAULT_WINDOW_WIDTH = 32,
  parameter int DEFAULT_PERIOD0      = 20000,
  parameter int DEFAULT_PERIOD1      = 10000
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  input  logic [7:0]                pixel_data,
  input  logic                      pixel_valid,
  input  logic                      line_start,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      cfg_we,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [31:0]               cfg_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_index,
  output logic [COUNT_WIDTH-1:0]    out_data,
  output logic                      busy,
  output logic                      irq
);
  localparam int WORDS = 3 * CHANNELS;
  localparam int IDXW  = $clog2(WORDS);
  localparam int PIW   = PIXEL_INDEX_WIDTH;
  localparam int PW    = PERIOD_WIDTH;
  localparam int CW    = COUNT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]                    threshold;
  logic [PW-1:0]                 tolerance;
  logic [CHANNELS-1:0][PIW-1:0]  win_start, win_stop;
  logic [CHANNELS-1:0][PW-1:0]   period0, period1;
  logic [WORDS-1:0][CW-1:0]      words;
  logic [PIW-1:0]                pix_cnt, pix_idx;
  logic [IDXW-1:0]               widx, widx_nxt;
  logic                          init, run, clr, last_hs;
  logic [CFG_ADDR_WIDTH-1:0]     cfg_off;
  logic                          cfg_hit, unused_bits;

  assign init     = (state == IDLE) && start;
  assign run      = (state == RUN);
  assign clr      = clear && ((state == IDLE) || (state == RUN));
  assign widx_nxt = widx + IDXW'(1);
  assign last_hs  = out_valid && out_ready && (widx == IDXW'(WORDS - 1));
  assign busy     = (state == RUN) || (state == DUMP);
  assign irq      = (state == DONE);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (stop) state_nxt = DUMP;
      DUMP: if (last_hs) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel registers sit at 2+4c: start, stop, period0, period1.
  assign cfg_off     = cfg_addr - CFG_ADDR_WIDTH'(2);
  assign cfg_hit     = (cfg_addr >= CFG_ADDR_WIDTH'(2)) &&
                       (cfg_addr < CFG_ADDR_WIDTH'(2 + 4 * CHANNELS));
  assign unused_bits = ^cfg_wdata;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      threshold <= 8'(DEFAULT_THRESHOLD);
      tolerance <= PW'(DEFAULT_TOLERANCE);
      for (int c = 0; c < CHANNELS; c++) begin
        win_start[c] <= PIW'(16 + c * 256);
        win_stop[c]  <= PIW'(16 + c * 256 + DEFAULT_WINDOW_WIDTH);
        period0[c]   <= PW'(DEFAULT_PERIOD0);
        period1[c]   <= PW'(DEFAULT_PERIOD1);
      end
    end else if (cfg_we && (state == IDLE)) begin
      if (cfg_addr == '0) threshold <= cfg_wdata[7:0];
      else if (cfg_addr == CFG_ADDR_WIDTH'(1)) tolerance <= cfg_wdata[PW-1:0];
      else if (cfg_hit) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (cfg_off[CFG_ADDR_WIDTH-1:2] == (CFG_ADDR_WIDTH-2)'(c)) begin
            case (cfg_off[1:0])
              2'd0:    win_start[c] <= cfg_wdata[PIW-1:0];
              2'd1:    win_stop[c]  <= cfg_wdata[PIW-1:0];
              2'd2:    period0[c]   <= cfg_wdata[PW-1:0];
              default: period1[c]   <= cfg_wdata[PW-1:0];
            endcase
          end
        end
      end
    end
  end

  // pix_cnt holds the index the next valid pixel will get unless line_start overrides it.
  assign pix_idx = line_start ? '0 : pix_cnt;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) pix_cnt <= '0;
    else if (init) pix_cnt <= '0;
    else if (run) begin
      if (pixel_valid) pix_cnt <= (&pix_idx) ? pix_idx : pix_idx + PIW'(1);
      else if (line_start) pix_cnt <= '0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    max_q, max_base;
    logic          sample, sample_d, armed;
    logic          win_ok, in_win, at_stop, rise, is_f0, is_f1;
    logic [PW-1:0] per_cnt, d0, d1;
    logic [CW-1:0] f0, f1, unk;

    assign win_ok   = win_stop[c] > win_start[c];
    assign in_win   = pixel_valid && win_ok && (pix_idx >= win_start[c]) && (pix_idx < win_stop[c]);
    assign at_stop  = pixel_valid && (pix_idx == win_stop[c]);
    assign max_base = line_start ? '0 : max_q;
    assign rise     = sample && !sample_d;
    assign d0       = (per_cnt >= period0[c]) ? per_cnt - period0[c] : period0[c] - per_cnt;
    assign d1       = (per_cnt >= period1[c]) ? per_cnt - period1[c] : period1[c] - per_cnt;
    // A saturated period is never trusted, so it falls through to unknown.
    assign is_f0    = !(&per_cnt) && (d0 <= tolerance);
    assign is_f1    = !(&per_cnt) && !is_f0 && (d1 <= tolerance);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
        max_q    <= '0;
        sample   <= 1'b0;
        sample_d <= 1'b0;
      end else if (init) begin
        max_q    <= '0;
        sample   <= 1'b0;
        sample_d <= 1'b0;
      end else if (run) begin
        sample_d <= sample;
        if (at_stop) begin
          sample <= win_ok && (max_base > threshold);
          max_q  <= '0;
        end else if (in_win && (pixel_data > max_base)) max_q <= pixel_data;
        else max_q <= max_base;
      end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
        per_cnt <= '0;
        armed   <= 1'b0;
        f0      <= '0;
        f1      <= '0;
        unk     <= '0;
      end else if (init || clr) begin
        per_cnt <= '0;
        armed   <= 1'b0;
        f0      <= '0;
        f1      <= '0;
        unk     <= '0;
      end else if (run) begin
        if (rise) begin
          per_cnt <= '0;
          armed   <= 1'b1;
          if (armed) begin
            if (is_f0)      f0  <= (&f0)  ? f0  : f0  + CW'(1);
            else if (is_f1) f1  <= (&f1)  ? f1  : f1  + CW'(1);
            else            unk <= (&unk) ? unk : unk + CW'(1);
          end
        end else if (!(&per_cnt)) per_cnt <= per_cnt + PW'(1);
      end
    end

    assign words[3*c]   = f0;
    assign words[3*c+1] = f1;
    assign words[3*c+2] = unk;
  end

  // Word 0 is loaded on the first DUMP cycle; each handshake loads the next one.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      widx      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else if (state != DUMP) begin
      widx      <= '0;
      out_valid <= 1'b0;
    end else if (!out_valid) begin
      out_valid <= 1'b1;
      out_index <= 8'(widx);
      out_data  <= words[widx];
    end else if (out_ready) begin
      if (widx == IDXW'(WORDS - 1)) out_valid <= 1'b0;
      else begin
        widx      <= widx_nxt;
        out_index <= 8'(widx_nxt);
        out_data  <= words[widx_nxt];
      end
    end
  end
endmodule
